// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared pipeline types: register index, data word, boolean and
//               the reg_writer bundle that carries a pending GPR write.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  typedef logic [4:0]  reg_addr;
  typedef logic [31:0] word_t;
  typedef logic        bool;

  typedef struct packed {
    bool     reg_write_enable;
    reg_addr reg_dest_addr;
    word_t   reg_write_data;
  } reg_writer;

endpackage
`default_nettype wire

// File: rtl/regread_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regread_pkg
// Description : Types local to the register-read unit: operand source select
//               and the registered operand pair handed to execute.
// Revision    : 1.0 - initial release
// ============================================================================
package regread_pkg;

  import core_pkg::*;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    EX   = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3,
    RF   = 3'd4
  } operand_src_e;

  typedef struct packed {
    word_t rs1_data;
    word_t rs2_data;
  } operand_buf_t;

endpackage
`default_nettype wire

// File: rtl/operand_forward.sv
`default_nettype none
// ============================================================================
// Module      : operand_forward
// Description : Combinational resolver for one source operand. Picks the
//               youngest in-flight producer of addr, falling back to the
//               register file, and flags a hazard when that producer's data
//               is not yet available.
// Ports       : addr                      - source register index
//               ex_wr / ex_is_load        - execute-stage bundle, load flag
//               mem_wr / mem_pending      - memory-stage bundle, data pending
//               wb_wr                     - writeback bundle (same-cycle bypass)
//               rf_data                   - architectural value of addr
//               data / hazard             - resolved value, unresolvable flag
// Revision    : 1.0 - initial release
// ============================================================================
module operand_forward
  import core_pkg::*;
  import regread_pkg::*;
(
  input  reg_addr   addr,
  input  reg_writer ex_wr,
  input  bool       ex_is_load,
  input  reg_writer mem_wr,
  input  bool       mem_pending,
  input  reg_writer wb_wr,
  input  word_t     rf_data,
  output word_t     data,
  output bool       hazard
);

  operand_src_e src;
  logic         ex_hit;
  logic         mem_hit;
  logic         wb_hit;

  assign ex_hit  = ex_wr.reg_write_enable  && (ex_wr.reg_dest_addr  == addr);
  assign mem_hit = mem_wr.reg_write_enable && (mem_wr.reg_dest_addr == addr);
  assign wb_hit  = wb_wr.reg_write_enable  && (wb_wr.reg_dest_addr  == addr);

  // Youngest producer wins; x0 is checked first so a stage "writing" x0 can
  // never forward data or raise a hazard.
  always_comb begin
    src = RF;
    if (addr == '0)   src = ZERO;
    else if (ex_hit)  src = EX;
    else if (mem_hit) src = MEM;
    else if (wb_hit)  src = WB;
  end

  always_comb begin
    data   = '0;
    hazard = 1'b0;
    case (src)
      ZERO: data = '0;
      EX: begin
        data   = ex_wr.reg_write_data;
        hazard = ex_is_load;
      end
      MEM: begin
        data   = mem_wr.reg_write_data;
        hazard = mem_pending;
      end
      WB:      data = wb_wr.reg_write_data;
      default: data = rf_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_read_unit.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_unit
// Description : Architectural GPR file (x1..x31) with writeback commit, two
//               forwarded source-operand reads for decode, and a one-entry
//               valid/ready operand buffer feeding execute. Decode is stalled
//               while either operand depends on data not yet produced.
// Ports       : clk, reset                 - clock, sync active-high reset
//               in_valid / in_ready        - decode request handshake
//               rs1_addr, rs2_addr         - source indices
//               ex_wr, ex_is_load          - execute-stage producer
//               mem_wr, mem_pending        - memory-stage producer
//               wb_wr                      - committing write
//               flush                      - drop buffered / accepting operands
//               out_valid / out_ready      - execute handshake
//               rs1_data, rs2_data         - buffered operands
//               dbg_addr / dbg_data        - architectural read, no forwarding
//               stall_cnt                  - hazard stall cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module reg_read_unit
  import core_pkg::*;
  import regread_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  reg_addr          rs1_addr,
  input  reg_addr          rs2_addr,
  input  reg_writer        ex_wr,
  input  bool              ex_is_load,
  input  reg_writer        mem_wr,
  input  bool              mem_pending,
  input  reg_writer        wb_wr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output word_t            rs1_data,
  output word_t            rs2_data,
  input  reg_addr          dbg_addr,
  output word_t            dbg_data,
  output logic [CNT_W-1:0] stall_cnt
);

  word_t            gpr [NREG];
  word_t            fwd_rs1;
  word_t            fwd_rs2;
  bool              haz_rs1;
  bool              haz_rs2;
  logic             hazard;
  logic             accept;
  operand_buf_t     buf_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] stall_q;

  // --------------------------------------------------------------------------
  // Operand resolution
  // --------------------------------------------------------------------------
  operand_forward u_fwd_rs1 (
    .addr        (rs1_addr),
    .ex_wr       (ex_wr),
    .ex_is_load  (ex_is_load),
    .mem_wr      (mem_wr),
    .mem_pending (mem_pending),
    .wb_wr       (wb_wr),
    .rf_data     (gpr[rs1_addr]),
    .data        (fwd_rs1),
    .hazard      (haz_rs1)
  );

  operand_forward u_fwd_rs2 (
    .addr        (rs2_addr),
    .ex_wr       (ex_wr),
    .ex_is_load  (ex_is_load),
    .mem_wr      (mem_wr),
    .mem_pending (mem_pending),
    .wb_wr       (wb_wr),
    .rf_data     (gpr[rs2_addr]),
    .data        (fwd_rs2),
    .hazard      (haz_rs2)
  );

  assign hazard   = haz_rs1 || haz_rs2;
  assign in_ready = !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Architectural register file. Entry 0 is cleared on reset and never
  // written afterwards, so it reads as zero without special casing.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        gpr[i] <= '0;
      end
    end else if (wb_wr.reg_write_enable && (wb_wr.reg_dest_addr != '0)) begin
      gpr[wb_wr.reg_dest_addr] <= wb_wr.reg_write_data;
    end
  end

  // Debug port sees only committed state: the same-cycle wb write is not
  // bypassed here.
  assign dbg_data = (dbg_addr == '0) ? '0 : gpr[dbg_addr];

  // --------------------------------------------------------------------------
  // Operand buffer. Flush outranks an accept in the same cycle; data is only
  // loaded on a surviving accept so a stalled buffer stays stable.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      buf_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      buf_q       <= '{rs1_data: fwd_rs1, rs2_data: fwd_rs2};
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign rs1_data  = buf_q.rs1_data;
  assign rs2_data  = buf_q.rs2_data;

  // --------------------------------------------------------------------------
  // Hazard stall counter (free-running wrap)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (in_valid && hazard && !flush) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_read_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_read_unit
// Description : Self-checking bench for reg_read_unit: reference model of the
//               GPRs and forwarding, expected-operand queue, vector table and
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_read_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  reg_addr     rs1_addr, rs2_addr, dbg_addr;
  reg_writer   ex_wr, mem_wr, wb_wr;
  bool         ex_is_load, mem_pending;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  word_t       rs1_data, rs2_data, dbg_data;
  logic [63:0] stall_cnt;

  always #5 clk = ~clk;

  reg_read_unit #(.NREG(32), .CNT_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .ex_wr       (ex_wr),
    .ex_is_load  (ex_is_load),
    .mem_wr      (mem_wr),
    .mem_pending (mem_pending),
    .wb_wr       (wb_wr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .stall_cnt   (stall_cnt)
  );

  typedef struct packed { word_t r1; word_t r2; } exp_t;
  typedef struct {
    reg_addr   r1, r2;
    reg_writer ex, mem, wb;
    word_t     e1, e2;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  word_t       mgpr [32];
  bit          exp_ov;
  logic [63:0] exp_stall;
  exp_t        exp_q [$];
  vec_t        tbl [8];

  function automatic reg_writer wr(input bit en, input reg_addr a, input word_t d);
    reg_writer w;
    w.reg_write_enable = en;
    w.reg_dest_addr    = a;
    w.reg_write_data   = d;
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference operand resolution, written from the priority list.
  function automatic void resolve(input reg_addr a, output word_t d, output bit hz);
    d = '0; hz = 1'b0;
    if (a == 0) d = '0;
    else if (ex_wr.reg_write_enable && ex_wr.reg_dest_addr == a) begin
      if (ex_is_load) hz = 1'b1; else d = ex_wr.reg_write_data;
    end else if (mem_wr.reg_write_enable && mem_wr.reg_dest_addr == a) begin
      if (mem_pending) hz = 1'b1; else d = mem_wr.reg_write_data;
    end else if (wb_wr.reg_write_enable && wb_wr.reg_dest_addr == a) d = wb_wr.reg_write_data;
    else d = mgpr[a];
  endfunction

  task automatic idle();
    in_valid = 0; flush = 0;
    ex_wr = '0; mem_wr = '0; wb_wr = '0;
    ex_is_load = 0; mem_pending = 0;
    rs1_addr = 0; rs2_addr = 0;
  endtask

  // One clock: check handshake/registered state against the model, score
  // any consumed operands, advance the model, then cross the edge.
  task automatic step();
    word_t d1, d2;
    bit h1, h2, rdy, acc;
    exp_t e;
    #2;
    resolve(rs1_addr, d1, h1);
    resolve(rs2_addr, d2, h2);
    rdy = !(h1 || h2) && (!exp_ov || out_ready);
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
    chk("stall_cnt", stall_cnt, exp_stall);
    if (exp_ov && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: got out_valid with empty queue expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rs1", {32'd0, rs1_data}, {32'd0, e.r1});
        chk("sb_rs2", {32'd0, rs2_data}, {32'd0, e.r2});
      end
    end else if (exp_ov && flush && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    acc = in_valid && rdy;
    if (reset) begin
      exp_ov = 0; exp_stall = '0; exp_q.delete();
      for (int i = 0; i < 32; i++) mgpr[i] = '0;
    end else begin
      if (acc && !flush) exp_q.push_back('{d1, d2});
      if (flush) exp_ov = 0;
      else if (acc) exp_ov = 1;
      else if (exp_ov && out_ready) exp_ov = 0;
      if (in_valid && (h1 || h2) && !flush) exp_stall++;
      if (wb_wr.reg_write_enable && wb_wr.reg_dest_addr != 0)
        mgpr[wb_wr.reg_dest_addr] = wb_wr.reg_write_data;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // r1, r2, ex, mem, wb, expected rs1, expected rs2
    tbl[0] = '{5'd5, 5'd0, '0, '0, '0, 32'h1234, 32'h0};
    tbl[1] = '{5'd7, 5'd5, '0, '0, wr(1, 7, 32'hAA), 32'hAA, 32'h1234};
    tbl[2] = '{5'd7, 5'd7, wr(1, 7, 32'hBB), '0, wr(1, 7, 32'hCC), 32'hBB, 32'hBB};
    tbl[3] = '{5'd7, 5'd9, wr(1, 3, 32'h11), wr(1, 9, 32'h55), '0, 32'hCC, 32'h55};
    tbl[4] = '{5'd9, 5'd5, wr(1, 9, 32'h66), wr(1, 9, 32'h77), '0, 32'h66, 32'h1234};
    tbl[5] = '{5'd0, 5'd0, wr(1, 0, 32'hFF), '0, wr(1, 0, 32'hFF), 32'h0, 32'h0};
    tbl[6] = '{5'd5, 5'd7, '0, wr(1, 5, 32'h88), wr(1, 5, 32'h99), 32'h88, 32'hCC};
    tbl[7] = '{5'd5, 5'd2, wr(0, 5, 32'hDEAD), '0, '0, 32'h99, 32'h0};

    idle(); out_ready = 1; dbg_addr = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1;
    exp_ov = 0; exp_stall = '0;
    for (int i = 0; i < 32; i++) mgpr[i] = '0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_rs1", {32'd0, rs1_data}, 64'd0);
    chk("rst_rs2", {32'd0, rs2_data}, 64'd0);
    chk("rst_stall", stall_cnt, 64'd0);
    reset = 0;

    // Commit x5 then read it back through the buffer
    wb_wr = wr(1, 5, 32'h1234);
    step(); idle();
    in_valid = 1; rs1_addr = 5; rs2_addr = 0;
    step(); idle();
    chk("first_rs1", {32'd0, rs1_data}, 64'h1234);
    chk("first_rs2", {32'd0, rs2_data}, 64'h0);
    dbg_addr = 5; #1;
    chk("dbg_x5", {32'd0, dbg_data}, 64'h1234);

    // Forwarding vector table
    for (int i = 0; i < 8; i++) begin
      rs1_addr = tbl[i].r1; rs2_addr = tbl[i].r2;
      ex_wr = tbl[i].ex; mem_wr = tbl[i].mem; wb_wr = tbl[i].wb;
      in_valid = 1;
      step(); idle();
      chk("tbl_rs1", {32'd0, rs1_data}, {32'd0, tbl[i].e1});
      chk("tbl_rs2", {32'd0, rs2_data}, {32'd0, tbl[i].e2});
    end
    step();

    // Write to x0 is ignored; dbg does not see same-cycle wb write
    wb_wr = wr(1, 0, 32'hFF); step(); idle();
    dbg_addr = 0; #1;
    chk("dbg_x0", {32'd0, dbg_data}, 64'h0);
    wb_wr = wr(1, 5, 32'hABC); dbg_addr = 5; #1;
    chk("dbg_no_bypass", {32'd0, dbg_data}, 64'h99);
    step(); idle(); #1;
    chk("dbg_after_commit", {32'd0, dbg_data}, 64'hABC);

    // Load-use stall for two cycles, then release
    ex_wr = wr(1, 3, 32'h42); ex_is_load = 1; rs2_addr = 3; in_valid = 1;
    step(); step();
    chk("loaduse_stall_cnt", stall_cnt, 64'd2);
    ex_is_load = 0;
    step(); idle();
    chk("loaduse_rs2", {32'd0, rs2_data}, 64'h42);

    // Memory data pending
    mem_wr = wr(1, 9, 32'h55); mem_pending = 1; rs1_addr = 9; in_valid = 1;
    step();
    mem_pending = 0;
    step(); idle();
    chk("mempend_rs1", {32'd0, rs1_data}, 64'h55);
    chk("mempend_stall_cnt", stall_cnt, 64'd3);
    step();

    // Backpressure: buffer holds A while B waits
    out_ready = 0; in_valid = 1; rs1_addr = 7; rs2_addr = 5;
    step();
    rs1_addr = 5; rs2_addr = 7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_rs1", {32'd0, rs1_data}, 64'hCC);
      chk("bp_hold_rs2", {32'd0, rs2_data}, 64'hABC);
    end
    out_ready = 1;
    step(); idle();
    step();

    // Back-to-back accepts at one per cycle
    in_valid = 1;
    rs1_addr = 5; rs2_addr = 7; step();
    rs1_addr = 7; rs2_addr = 0; step();
    rs1_addr = 0; rs2_addr = 5; step();
    idle(); step();

    // Flush on an accepting cycle drops it
    in_valid = 1; flush = 1; rs1_addr = 5;
    step(); idle();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    step();

    // Flush during a hazard does not count a stall
    ex_wr = wr(1, 4, 32'h0); ex_is_load = 1; rs1_addr = 4; in_valid = 1; flush = 1;
    step();
    flush = 0;
    chk("flush_no_stall", stall_cnt, 64'd3);

    // Reset mid-stall clears counter, buffer and GPRs (reset beats commit)
    step();
    reset = 1; wb_wr = wr(1, 7, 32'h77);
    step();
    reset = 0; idle();
    dbg_addr = 7; #1;
    chk("rst_mid_stall_cnt", stall_cnt, 64'd0);
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_dbg_x7", {32'd0, dbg_data}, 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_read_unit.md
Name: reg_read_unit

Overview:
- Consumer side of the `reg_writer` bundle.
- Holds architectural GPRs x1..x31 and commits the writeback-stage `reg_writer`.
- Serves the decode stage's two source-operand reads, forwarding from in-flight EX/MEM/WB `reg_writer` bundles.
- Registers the operands into a 1-entry valid/ready output buffer feeding execute, and stalls decode on unresolvable hazards.

Parameters:
- NREG, 32, architectural register count (x0 hardwired zero).
- CNT_W, 64, width of the hazard-stall performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents a read request.
- in_ready  out  1  request accepted this cycle.
- rs1_addr  in  reg_addr  source 1 index.
- rs2_addr  in  reg_addr  source 2 index.
- ex_wr  in  reg_writer  bundle currently in execute.
- ex_is_load  in  bool  execute instruction is a load (data not yet available).
- mem_wr  in  reg_writer  bundle currently in memory stage.
- mem_pending  in  bool  memory-stage data not yet returned.
- wb_wr  in  reg_writer  bundle committing this cycle.
- flush  in  1  discard buffered operands (branch/jump redirect).
- out_valid  out  1  operand buffer holds valid data.
- out_ready  in  1  execute consumes buffer.
- rs1_data  out  word_t  buffered operand 1.
- rs2_data  out  word_t  buffered operand 2.
- dbg_addr  in  reg_addr  difftest read index.
- dbg_data  out  word_t  architectural value, no forwarding.
- stall_cnt  out  CNT_W  cycles in which in_valid=1 and a hazard forced in_ready=0.

Behaviour:
- Reset (synchronous, at clk edge with reset=1): all GPRs=0, out_valid=0, rs1_data=rs2_data=0, stall_cnt=0. Reset has priority over flush and over any commit in the same cycle.
- Commit: at posedge, if `wb_wr.reg_write_enable` && `reg_dest_addr`!=0, GPR[addr] <= `reg_write_data`. Writes to x0 are ignored.
- Operand resolution (combinational, per source, first match wins):
  1. addr==0 -> 0.
  2. ex_wr enabled && dest==addr -> hazard if ex_is_load, else `ex_wr` data.
  3. mem_wr enabled && dest==addr -> hazard if mem_pending, else `mem_wr` data.
  4. wb_wr enabled && dest==addr -> `wb_wr` data (same-cycle write/read bypass).
  5. else GPR[addr].
- Hazard evaluation: only a matching, enabled, non-zero dest is a hazard; a younger non-matching stage never masks an older match.
- Handshake:
  - in_ready = !hazard && (!out_valid || out_ready).
  - Accept = in_valid && in_ready; on accept, operands load into the buffer and out_valid <= 1 (latency 1 cycle).
  - out_valid && out_ready && !accept -> out_valid <= 0.
  - Back-to-back accepts sustain 1 request/cycle.
  - While out_valid=1 and out_ready=0, buffer contents are held stable.
- flush: out_valid <= 0 next cycle and the same-cycle accept is dropped. GPR commit still occurs. flush does not affect stall_cnt.
- stall_cnt: increments by 1 when in_valid && hazard && !flush. Wraps modulo 2^CNT_W.
- dbg_data = GPR[dbg_addr]; 0 for x0. Reflects commits of the previous edge, not the same-cycle wb write.
- Reset asserted mid-stall: the buffer empties and the counter clears. The pending request is re-presented by decode.

Decomposition:
- Package `regread_pkg`: typedef `operand_src_e` (ZERO, EX, MEM, WB, RF) and typedef `operand_buf_t` {rs1_data, rs2_data}.
- `reg_writer`, `reg_addr`, `word_t` and `bool` continue to come from the existing shared packages.
- Sub-module `operand_forward`: pure combinational single-source resolver returning {data, hazard}. It is instantiated twice; the sequential buffer, GPR array and counter stay in the top.

Test Plan:
- Reset, then wb_wr={x5, en, 0x1234}, then read rs1=x5, rs2=x0 -> next cycle out_valid=1, rs1_data=0x1234, rs2_data=0; dbg_data(x5)=0x1234.
- Same-cycle bypass: wb_wr={x7, en, 0xAA} with rs1=x7 -> rs1_data=0xAA. ex_wr={x7, 0xBB} also present -> 0xBB wins.
- Load-use: ex_wr={x3, en}, ex_is_load=1, rs2=x3, in_valid=1 for 2 cycles -> in_ready=0, stall_cnt=2. Drop ex_is_load -> accept next cycle.
- mem_pending with mem_wr={x9, en, 0x55}, rs1=x9 -> stall. Deassert mem_pending -> rs1_data=0x55.
- Backpressure: out_ready=0 with buffer full -> in_ready=0 and rs1/rs2_data stable 3 cycles. out_ready=1 -> accept resumes, no data lost.
- Writes to x0 ({x0, en, 0xFF}) -> dbg_data(x0)=0. flush during accept -> out_valid=0 next cycle. reset mid-stall -> stall_cnt=0, out_valid=0.
